fir_out_requant_decim: RTL and testbench

- Downstream stage of the FIR filter. Consumes the filter's full-width output stream (valid_in/din) and keeps every DECIM-th sample.
- Each kept sample is rounded by discarding SHIFT LSBs, then saturated to OUT_WIDTH signed.
- Results are buffered in a small FIFO with a valid/ready handshake, because the FIR has no backpressure.
- FIFO overflow drops and saturation events are reported on status ports.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_sync_fifo.sv | 64 ++++++
 rtl/fir_out_requant_decim.sv | 174 +++++++++++++++++
 tb/tb_fir_out_requant_decim.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, constants and parameter legality check for the FIR output stage
// Contents:
//   round_mode_e : rounding mode applied before requantisation
//   DROP_CNT_W   : width of the FIFO overflow drop counter
//   params_ok()  : elaboration-time legality check of the requantiser parameter set
package fir_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    localparam int DROP_CNT_W = 8;

    function automatic bit params_ok(
        input int in_width,
        input int out_width,
        input int shift,
        input int decim,
        input int round_mode,
        input int fifo_depth
    );
        return (shift >= 1)
            && (in_width - shift >= out_width)
            && (decim >= 1)
            && (round_mode == 0 || round_mode == 1)
            && (fifo_depth >= 2)
            && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - generic synchronous FIFO, power-of-two depth
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write request and data; accepted when not full, or when full with a pop in the same cycle
//   full         : no free entry
//   pop          : read request; ignored when empty
//   rdata, empty : head entry (only meaningful when !empty), FIFO empty
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_requant_decim.sv
// rtl/fir_out_requant_decim.sv - FIR output decimator, round/saturate requantiser and output FIFO
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   valid_in, din     : full-width signed FIR output stream (no backpressure)
//   clr_flags         : synchronous clear of sat_flag and drop_cnt
//   valid_out, dout   : FIFO head; dout holds its last value while empty
//   ready_out         : consumer accept; pop when valid_out && ready_out
//   sat_flag          : sticky, set when a kept sample was clamped
//   drop_cnt          : samples lost on a full FIFO, saturating
module fir_out_requant_decim
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 26,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 10,
    parameter int DECIM      = 4,
    parameter int ROUND_MODE = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [IN_WIDTH-1:0]   din,
    input  logic                         clr_flags,
    output logic                         valid_out,
    output logic signed [OUT_WIDTH-1:0]  dout,
    input  logic                         ready_out,
    output logic                         sat_flag,
    output logic [DROP_CNT_W-1:0]        drop_cnt
);

    if (!params_ok(IN_WIDTH, OUT_WIDTH, SHIFT, DECIM, ROUND_MODE, FIFO_DEPTH)) begin : g_param_err
        $error("fir_out_requant_decim: illegal parameter set");
    end

    localparam int          PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int          W1    = IN_WIDTH + 1 - SHIFT;
    localparam round_mode_e RMODE = round_mode_e'(ROUND_MODE[0]);

    localparam logic signed [IN_WIDTH:0] RND_BIAS = (IN_WIDTH+1)'(1) << (SHIFT - 1);
    localparam logic signed [W1-1:0] SAT_MAX = {{(W1-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W1-1:0] SAT_MIN = {{(W1-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Decimation phase
    logic [PW-1:0] phase;
    logic          keep;

    assign keep = valid_in && (phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (valid_in) begin
            phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
        end
    end

    // Stage 1: bias then drop SHIFT LSBs; one guard bit keeps the bias add from overflowing
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] biased;
    logic                     unused_lsbs;
    logic                     s1_valid;
    logic signed [W1-1:0]     s1_data;

    always_comb begin
        ext    = {din[IN_WIDTH-1], din};
        biased = (RMODE == RND_HALF_UP) ? ext + RND_BIAS : ext;
    end

    // Taking the upper bits of the biased value is the arithmetic right shift.
    assign unused_lsbs = ^biased[SHIFT-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            s1_data  <= biased[IN_WIDTH:SHIFT];
        end
    end

    // Stage 2: clamp to the signed OUT_WIDTH range
    logic                 clamp_hi;
    logic                 clamp_lo;
    logic [OUT_WIDTH-1:0] clamped;
    logic                 sat_evt;
    logic                 s2_valid;
    logic [OUT_WIDTH-1:0] s2_data;

    always_comb begin
        clamp_hi = (s1_data > SAT_MAX);
        clamp_lo = (s1_data < SAT_MIN);
        clamped  = s1_data[OUT_WIDTH-1:0];
        if (clamp_hi) begin
            clamped = SAT_MAX[OUT_WIDTH-1:0];
        end else if (clamp_lo) begin
            clamped = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    assign sat_evt = s1_valid && (clamp_hi || clamp_lo);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_data  <= clamped;
        end
    end

    // Output FIFO
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OUT_WIDTH-1:0] fifo_head;
    logic                 pop;
    logic                 drop_evt;
    logic [OUT_WIDTH-1:0] last_q;

    assign valid_out = !fifo_empty;
    assign pop       = valid_out && ready_out;
    assign drop_evt  = s2_valid && fifo_full && !pop;
    // Once drained, dout keeps showing the most recently popped sample.
    assign dout      = fifo_empty ? last_q : fifo_head;

    fir_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_valid),
        .wdata (s2_data),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (fifo_head),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= fifo_head;
        end
    end

    // Status flags: a new event in the same cycle as clr_flags takes precedence
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (sat_evt) begin
                sat_flag <= 1'b1;
            end else if (clr_flags) begin
                sat_flag <= 1'b0;
            end

            if (drop_evt) begin
                if (clr_flags) begin
                    drop_cnt <= DROP_CNT_W'(1);
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end else if (clr_flags) begin
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_out_requant_decim.sv
// tb/tb_fir_out_requant_decim.sv - self-checking bench for fir_out_requant_decim
module tb_fir_out_requant_decim;

    logic                clk = 1'b0;
    logic                rst;
    logic                valid_in;
    logic signed [25:0]  din;
    logic                clr_flags;
    logic                ready_out;

    logic                vo [4];
    logic signed [15:0]  dq [4];
    logic                sf [4];
    logic [7:0]          dc [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: DECIM 4 half-up, 1: DECIM 1 half-up, 2: DECIM 1 truncate, 3: DECIM 2 half-up
    fir_out_requant_decim #(.DECIM(4), .ROUND_MODE(1)) u_r4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .clr_flags(clr_flags),
        .valid_out(vo[0]), .dout(dq[0]), .ready_out(ready_out), .sat_flag(sf[0]), .drop_cnt(dc[0]));
    fir_out_requant_decim #(.DECIM(1), .ROUND_MODE(1)) u_d1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .clr_flags(clr_flags),
        .valid_out(vo[1]), .dout(dq[1]), .ready_out(ready_out), .sat_flag(sf[1]), .drop_cnt(dc[1]));
    fir_out_requant_decim #(.DECIM(1), .ROUND_MODE(0)) u_t1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .clr_flags(clr_flags),
        .valid_out(vo[2]), .dout(dq[2]), .ready_out(ready_out), .sat_flag(sf[2]), .drop_cnt(dc[2]));
    fir_out_requant_decim #(.DECIM(2), .ROUND_MODE(1)) u_d2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .clr_flags(clr_flags),
        .valid_out(vo[3]), .dout(dq[3]), .ready_out(ready_out), .sat_flag(sf[3]), .drop_cnt(dc[3]));

    // Reference model: queues of in-flight and buffered samples per instance
    typedef struct {
        longint val;
        bit     sat;
        longint push_cyc;
    } item_t;

    item_t  pq [4][$];
    longint fq [4][$];
    longint mlast [4];
    bit     msat  [4];
    int     mdrop [4];
    longint nval  [4];
    longint cyc = 0;
    int     decim_m [4] = '{4, 1, 1, 2};
    int     mode_m  [4] = '{1, 1, 0, 1};

    task automatic requant(input longint x, input int mode, output longint q, output bit sat);
        longint t;
        t = x + (mode != 0 ? 512 : 0);
        q = t / 1024;
        if (t < 0 && q * 1024 != t) q = q - 1;
        sat = 1'b0;
        if (q > 32767)  begin q = 32767;  sat = 1'b1; end
        if (q < -32768) begin q = -32768; sat = 1'b1; end
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            bit     new_sat;
            bit     drop;
            longint q;
            bit     s;
            item_t  it;
            if (rst) begin
                fq[i].delete();
                pq[i].delete();
                nval[i]  = 0;
                msat[i]  = 1'b0;
                mdrop[i] = 0;
                mlast[i] = 0;
                continue;
            end
            new_sat = 1'b0;
            drop    = 1'b0;
            if (fq[i].size() > 0 && ready_out) mlast[i] = fq[i].pop_front();
            while (pq[i].size() > 0 && pq[i][0].push_cyc == cyc) begin
                it = pq[i].pop_front();
                if (fq[i].size() < 4) fq[i].push_back(it.val);
                else drop = 1'b1;
            end
            for (int k = 0; k < pq[i].size(); k++)
                if (pq[i][k].push_cyc == cyc + 1 && pq[i][k].sat) new_sat = 1'b1;
            if (valid_in) begin
                if (nval[i] % decim_m[i] == 0) begin
                    requant(longint'(din), mode_m[i], q, s);
                    it.val = q;
                    it.sat = s;
                    it.push_cyc = cyc + 2;
                    pq[i].push_back(it);
                end
                nval[i]++;
            end
            if (new_sat) msat[i] = 1'b1;
            else if (clr_flags) msat[i] = 1'b0;
            if (drop) mdrop[i] = clr_flags ? 1 : (mdrop[i] < 255 ? mdrop[i] + 1 : 255);
            else if (clr_flags) mdrop[i] = 0;
        end
        cyc++;
    endtask

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0d expected=%0d cycle=%0d", name, inst, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 4; i++) begin
            chk("model_valid_out", i, longint'(vo[i]), longint'(fq[i].size() > 0));
            chk("model_dout", i, longint'(dq[i]), fq[i].size() > 0 ? fq[i][0] : mlast[i]);
            chk("model_sat_flag", i, longint'(sf[i]), longint'(msat[i]));
            chk("model_drop_cnt", i, longint'(dc[i]), longint'(mdrop[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        valid_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int din;
        int exp_hu;
        int exp_tr;
        bit exp_sat;
    } vec_t;

    vec_t   vecs [9];
    longint h [37];
    longint exp_q [$];
    longint obs [$];

    initial begin
        vecs[0] = '{512,        1,      0,      1'b0};
        vecs[1] = '{-512,       0,      -1,     1'b0};
        vecs[2] = '{511,        0,      0,      1'b0};
        vecs[3] = '{-513,       -1,     -1,     1'b0};
        vecs[4] = '{1023,       1,      0,      1'b0};
        vecs[5] = '{-1,         0,      -1,     1'b0};
        vecs[6] = '{1536,       2,      1,      1'b0};
        vecs[7] = '{33554431,   32767,  32767,  1'b1};
        vecs[8] = '{-33554432,  -32768, -32768, 1'b1};

        rst = 1'b1; valid_in = 1'b0; din = '0; clr_flags = 1'b0; ready_out = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("reset_valid_out", i, longint'(vo[i]), 0);
            chk("reset_dout", i, longint'(dq[i]), 0);
            chk("reset_sat_flag", i, longint'(sf[i]), 0);
            chk("reset_drop_cnt", i, longint'(dc[i]), 0);
        end

        // Ramp through DECIM 4: outputs 0,4,8,12 three cycles after their inputs
        for (int j = 0; j < 20; j++) begin
            bit ev;
            valid_in = (j < 16);
            din = 26'(j * 1024);
            tick();
            ev = (j >= 2) && (j <= 14) && ((j - 2) % 4 == 0);
            chk("ramp_valid_out", 0, longint'(vo[0]), longint'(ev));
            if (ev) chk("ramp_dout", 0, longint'(dq[0]), j - 2);
        end
        idle(2);

        // Rounding and saturation vectors through DECIM 1
        reset_pulse();
        for (int v = 0; v < 9; v++) begin
            valid_in = 1'b1;
            din = 26'(vecs[v].din);
            tick();
            valid_in = 1'b0;
            tick();
            tick();
            chk("vec_valid_out", 1, longint'(vo[1]), 1);
            chk("vec_half_up", 1, longint'(dq[1]), vecs[v].exp_hu);
            chk("vec_trunc", 2, longint'(dq[2]), vecs[v].exp_tr);
            chk("vec_sat_flag", 1, longint'(sf[1]), longint'(vecs[v].exp_sat));
            idle(2);
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_sat_flag", 1, longint'(sf[1]), 0);

        // Saturation landing in the same cycle as clr_flags: the event wins
        valid_in = 1'b1;
        din = 26'(33554431);
        tick();
        valid_in = 1'b0;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_vs_sat", 1, longint'(sf[1]), 1);
        chk("clr_vs_nosat", 2, longint'(sf[2]), 0);
        idle(3);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // Backpressure: 6 samples into a 4-deep FIFO
        reset_pulse();
        ready_out = 1'b0;
        for (int k = 0; k < 6; k++) begin
            valid_in = 1'b1;
            din = 26'((k + 1) * 1024);
            tick();
        end
        idle(3);
        chk("bp_valid_out", 1, longint'(vo[1]), 1);
        chk("bp_head", 1, longint'(dq[1]), 1);
        chk("bp_drop_cnt", 1, longint'(dc[1]), 2);
        chk("bp_drop_cnt_d4", 0, longint'(dc[0]), 0);
        ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", 1, longint'(vo[1]), 1);
            chk("bp_drain_dout", 1, longint'(dq[1]), k + 1);
            tick();
        end
        chk("bp_empty", 1, longint'(vo[1]), 0);
        chk("bp_hold_dout", 1, longint'(dq[1]), 4);

        // Reset with entries buffered
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_in = 1'b1;
            din = 26'((k + 7) * 1024);
            tick();
        end
        idle(3);
        chk("mid_buffered", 1, longint'(vo[1]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 1, longint'(vo[1]), 0);
        chk("mid_rst_drop", 1, longint'(dc[1]), 0);
        chk("mid_rst_valid_d4", 0, longint'(vo[0]), 0);
        ready_out = 1'b1;
        valid_in = 1'b1;
        din = 26'(5 * 1024);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        chk("mid_first_kept_valid", 0, longint'(vo[0]), 1);
        chk("mid_first_kept_dout", 0, longint'(dq[0]), 5);
        idle(2);

        // Pulse-response replay through DECIM 2
        for (int k = 0; k < 37; k++) begin
            int tri_v;
            tri_v = (k <= 18) ? k : 36 - k;
            h[k] = longint'(tri_v) * 1900000 - 4000000;
        end
        h[0] = -33554432;
        h[18] = 33554431;
        for (int k = 0; k < 37; k += 2) begin
            longint q;
            bit s;
            requant(h[k], 1, q, s);
            exp_q.push_back(q);
        end
        reset_pulse();
        ready_out = 1'b1;
        for (int k = 0; k < 45; k++) begin
            valid_in = (k < 37);
            din = (k < 37) ? 26'(h[k]) : '0;
            tick();
            if (vo[3]) obs.push_back(longint'(dq[3]));
        end
        chk("fir_count", 3, obs.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            chk("fir_sample", 3, (k < obs.size()) ? obs[k] : 99999, exp_q[k]);
        chk("fir_sat_flag", 3, longint'(sf[3]), 1);

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int t;
            valid_in  = ($urandom_range(0, 3) != 0);
            ready_out = ($urandom_range(0, 2) != 0);
            clr_flags = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0: t = int'($urandom);
                1: t = int'($urandom_range(0, 4095)) - 2048;
                2: t = 33554431 - int'($urandom_range(0, 1023));
                default: t = -33554432 + int'($urandom_range(0, 1023));
            endcase
            din = 26'(t);
            tick();
        end
        rst = 1'b0;
        clr_flags = 1'b0;
        ready_out = 1'b1;
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
